data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Shares one 9-bit-wide, 128-word synchronous data memory between two requesters (A: datapath load/store port, B: debug/loader port). It also owns a hardware clear sequencer that zero-fills the whole memory on command. The block sits between the requesters and the memory's write-enable/address/write-data/read-data pins, and is the only driver of those pins.

## Interface
- ADDR_W, 8, requester and memory address width
- DATA_W, 9, data width
- DEPTH, 128, number of memory words; clear sweep length
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- a_req / b_req  in  1  request valid; hold with we/addr/wdata stable until accepted
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  word address
- a_wdata / b_wdata  in  DATA_W  write data
- a_gnt / b_gnt  out  1  accept; combinational from req, state and priority; transfer occurs on an edge with req&gnt
- a_rvalid / b_rvalid  out  1  read data valid, one-cycle pulse
- a_rdata / b_rdata  out  DATA_W  equals mem_rdata; meaningful only while the matching rvalid=1
- clr_start  in  1  start a clear sweep; sampled only in IDLE
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- mem_we  out  1  registered memory write enable
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_addr is presented with mem_we=0

## Operation
- State machine has two states: IDLE and CLEAR.
- IDLE with clr_start=0:
  - If only one requester has req=1, it gets gnt.
  - If both do, round-robin applies: the requester not granted last wins.
  - The last_grant register updates on every accepted transfer.
  - At most one gnt is high per cycle.
- An accepted transfer registers mem_we=we, mem_addr=addr mod DEPTH (MSB forced 0 when DEPTH=128), and mem_wdata=wdata.
- In a cycle with no accepted transfer, mem_we=0 and mem_addr/mem_wdata hold their values.
- A read-tag pipeline (2 stages, each holding valid + requester ID) routes rvalid to the requester that issued the read.
- A write produces no rvalid.
- IDLE with clr_start=1:
  - Both gnt are 0 that cycle; clear takes priority over simultaneous requests.
  - Next state is CLEAR, with an internal counter set to 0.
- CLEAR:
  - clr_busy=1, both gnt=0.
  - Each cycle issues mem_we=1, mem_addr=counter, mem_wdata=0, then counter+1.
  - After issuing address DEPTH-1, the block returns to IDLE and pulses clr_done in the first IDLE cycle.
  - clr_start is ignored while in CLEAR.
- Reads accepted before entering CLEAR still complete and return rvalid during CLEAR.
- No hazard logic is needed: the memory processes operations in issue order, so a read issued after a write to the same address returns the new data.

## Timing
- Cycle N: req&gnt sampled at the edge.
- Cycle N+1: mem_* outputs carry the operation.
- Cycle N+2: for a read, rvalid=1 and rdata=mem_rdata.
- Read latency from acceptance is 2 cycles. Throughput is one transfer per cycle, fully pipelined.
- Clear sweep:
  - clr_busy rises the cycle after clr_start is sampled and stays high exactly DEPTH cycles.
  - mem_we=1 in each of those cycles with addresses 0..DEPTH-1.
  - clr_done pulses in the cycle after clr_busy falls.
  - gnt is possible again in the same cycle as clr_done.
- Reset values: state=IDLE, last_grant=B (A wins the first tie), mem_we=0, mem_addr=0, mem_wdata=0, a_gnt=b_gnt=0 during rst, a_rvalid=b_rvalid=0, clr_busy=0, clr_done=0, read-tag pipeline cleared.
- Reset mid-clear:
  - The sweep aborts in the next cycle and words not yet cleared keep their old contents.
  - No clr_done is produced.
- Reset with reads in flight: the pending rvalid pulses are dropped.
- Counter wraps are impossible: the counter width is ADDR_W and the sweep terminates at DEPTH-1.

## Test plan
- Basic read/write: A writes addr 5 = 0x1A5 and is accepted at edge N, then reads addr 5 at edge N+1. Expect mem_we=1 in N+1, a_rvalid=1 in N+3 with a_rdata=0x1A5, and b_rvalid=0 throughout.
- Round-robin: a_req=b_req=1 held for 4 cycles after reset. Expect grants A,B,A,B. Then only b_req for 2 cycles: expect b_gnt on both cycles.
- Alias: B writes addr 0x85 with data 0x033. Expect mem_addr=0x05, mem_wdata=0x033. Then A reads addr 0x05 and gets 0x033.
- Clear sweep: preload addr 127 = 0x0FF, then pulse clr_start with a_req=1 in the same cycle.
  - Expect a_gnt=0 and clr_busy=1 for 128 cycles, with mem_addr stepping 0..127 and mem_wdata=0.
  - Expect a_gnt=0 throughout, clr_done for 1 cycle, then A's read of 127 returns 0x000.
- In-flight read across clear: A read accepted at N and clr_start at N+1. Expect a_rvalid at N+2 with the pre-clear data while clr_busy=1.
- Reset mid-clear: assert rst when mem_addr=40 during CLEAR.
  - Expect all outputs at reset values the next cycle and clr_done never pulsing.
  - Address 50 keeps its pre-clear value; address 10 reads 0.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one synchronous data memory between two requesters
// (A: datapath, B: debug/loader) and owns a zero-fill clear sequencer.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_{a,b}_req/we/addr/wdata     requests, held stable until granted
//   o_{a,b}_gnt                   combinational accept (req & gnt at an edge = transfer)
//   o_{a,b}_rvalid/rdata          read return, two cycles after acceptance
//   i_clr_start, o_clr_busy/done  clear sweep control and status
//   o_mem_we/addr/wdata           registered memory pins; i_mem_rdata read data
module data_memory_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_gnt,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_gnt,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata,
  input  logic              i_clr_start,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  // DEPTH is a power of two, so the mask folds addresses modulo DEPTH
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_last_b;     // 1: last accepted transfer was B's
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_clr_done;
  logic                r_tag_vld;    // read tag stage 1: valid + requester id
  logic                r_tag_id;
  logic                r_a_rvalid;   // read tag stage 2, decoded per requester
  logic                r_b_rvalid;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                w_last_b_nxt;
  logic                w_mem_we_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   w_mem_wdata_nxt;
  logic                w_clr_done_nxt;
  logic                w_tag_vld_nxt;
  logic                w_tag_id_nxt;
  logic                w_a_gnt;
  logic                w_b_gnt;

  // Next-state, arbitration and memory-pin selection
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_b_nxt    = r_last_b;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_clr_done_nxt  = 1'b0;
    w_tag_vld_nxt   = 1'b0;
    w_tag_id_nxt    = r_tag_id;
    w_a_gnt         = 1'b0;
    w_b_gnt         = 1'b0;

    if (r_state == S_IDLE) begin
      if (i_clr_start) begin
        // First clear write goes out on the same edge that enters CLEAR
        w_state_nxt     = S_CLEAR;
        w_cnt_nxt       = '0;
        w_mem_we_nxt    = 1'b1;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
      end else begin
        // Round-robin on a tie: the requester not granted last wins
        w_a_gnt = i_a_req & (~i_b_req | r_last_b);
        w_b_gnt = i_b_req & (~i_a_req | ~r_last_b);
        if (w_a_gnt) begin
          w_mem_we_nxt    = i_a_we;
          w_mem_addr_nxt  = i_a_addr & ADDR_MASK;
          w_mem_wdata_nxt = i_a_wdata;
          w_last_b_nxt    = 1'b0;
          w_tag_vld_nxt   = ~i_a_we;
          w_tag_id_nxt    = 1'b0;
        end else if (w_b_gnt) begin
          w_mem_we_nxt    = i_b_we;
          w_mem_addr_nxt  = i_b_addr & ADDR_MASK;
          w_mem_wdata_nxt = i_b_wdata;
          w_last_b_nxt    = 1'b1;
          w_tag_vld_nxt   = ~i_b_we;
          w_tag_id_nxt    = 1'b1;
        end
      end
    end else begin
      // r_cnt is the address currently on the memory pins
      if (r_cnt == LAST_ADDR) begin
        w_state_nxt    = S_IDLE;
        w_clr_done_nxt = 1'b1;
      end else begin
        w_cnt_nxt       = r_cnt + ADDR_W'(1);
        w_mem_we_nxt    = 1'b1;
        w_mem_addr_nxt  = r_cnt + ADDR_W'(1);
        w_mem_wdata_nxt = '0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_b    <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_clr_done  <= 1'b0;
      r_tag_vld   <= 1'b0;
      r_tag_id    <= 1'b0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_b    <= w_last_b_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_clr_done  <= w_clr_done_nxt;
      r_tag_vld   <= w_tag_vld_nxt;
      r_tag_id    <= w_tag_id_nxt;
      r_a_rvalid  <= r_tag_vld & ~r_tag_id;
      r_b_rvalid  <= r_tag_vld & r_tag_id;
    end
  end

  assign o_a_gnt     = w_a_gnt & ~rst;
  assign o_b_gnt     = w_b_gnt & ~rst;
  assign o_a_rvalid  = r_a_rvalid;
  assign o_b_rvalid  = r_b_rvalid;
  assign o_a_rdata   = i_mem_rdata;
  assign o_b_rdata   = i_mem_rdata;
  assign o_clr_busy  = (r_state == S_CLEAR);
  assign o_clr_done  = r_clr_done;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed and randomized checks of data_memory_arbiter
// against a transaction-level model, with a behavioural synchronous memory.
module tb_data_memory_arbiter;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 9;
  localparam int unsigned DEPTH  = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, a_req, a_we, b_req, b_we, clr_start;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, a_rvalid, b_gnt, b_rvalid, clr_busy, clr_done, mem_we;
  logic [DATA_W-1:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
    .i_clr_start(clr_start), .o_clr_busy(clr_busy), .o_clr_done(clr_done),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Behavioural memory; preload copies the model's initial contents
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [DATA_W-1:0] mem     [0:DEPTH-1];
  logic              preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else begin
      if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[6:0]];
    end
  end

  int checks = 0;
  int errors = 0;

  // Transaction-level model of the expected pin values in the current cycle
  int                clr_left;   // remaining cycles of the clear sweep
  bit                m_last_b;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  bit                m_done;
  bit                p1_v, p1_b, p2_v, p2_b;
  logic [DATA_W-1:0] p1_d, p2_d;
  bit                ga, gb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    clr_left = 0; m_last_b = 1'b1; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_done = 1'b0; p1_v = 1'b0; p2_v = 1'b0; p1_b = 1'b0; p2_b = 1'b0;
    p1_d = '0; p2_d = '0;
  endtask

  task automatic accept(input bit is_b, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd);
    int idx;
    idx = int'(addr) % DEPTH;
    m_we = we; m_addr = ADDR_W'(idx); m_wdata = wd; m_last_b = is_b;
    if (we) ref_mem[idx] = wd;
    else begin p1_v = 1'b1; p1_b = is_b; p1_d = ref_mem[idx]; end
  endtask

  // One clock cycle: check this cycle's outputs, advance the model, cross the edge
  task automatic tick();
    #1;
    ga = 1'b0; gb = 1'b0;
    if (!rst && clr_left == 0 && !clr_start) begin
      if (a_req && (!b_req || m_last_b)) ga = 1'b1;
      else if (b_req) gb = 1'b1;
    end
    chk("a_gnt", 32'(a_gnt), 32'(ga));
    chk("b_gnt", 32'(b_gnt), 32'(gb));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("clr_busy", 32'(clr_busy), 32'(clr_left > 0));
    chk("clr_done", 32'(clr_done), 32'(m_done));
    chk("a_rvalid", 32'(a_rvalid), 32'(p2_v && !p2_b));
    chk("b_rvalid", 32'(b_rvalid), 32'(p2_v && p2_b));
    if (p2_v && !p2_b) chk("a_rdata", 32'(a_rdata), 32'(p2_d));
    if (p2_v && p2_b)  chk("b_rdata", 32'(b_rdata), 32'(p2_d));
    if (rst) model_reset();
    else begin
      p2_v = p1_v; p2_b = p1_b; p2_d = p1_d; p1_v = 1'b0;
      m_done = 1'b0;
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) begin m_we = 1'b0; m_done = 1'b1; end
        else begin m_addr = m_addr + 1'b1; ref_mem[int'(m_addr)] = '0; end
      end else if (clr_start) begin
        clr_left = DEPTH; m_we = 1'b1; m_addr = '0; m_wdata = '0; ref_mem[0] = '0;
      end else if (ga) accept(1'b0, a_we, a_addr, a_wdata);
      else if (gb) accept(1'b1, b_we, b_addr, b_wdata);
      else m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    a_req = 1'b0; b_req = 1'b0; clr_start = 1'b0;
    repeat (n) tick();
  endtask

  // Issue one request and hold it until accepted (bounded)
  task automatic do_req(input bit is_b, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd);
    bit done;
    done = 1'b0;
    if (is_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = is_b ? gb : ga;
    end
    chk("req_accepted", 32'(done), 32'd1);
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic read_check(input bit is_b, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] exp, input string tag);
    do_req(is_b, 1'b0, addr, '0);
    tick();
    chk(tag, 32'(is_b ? b_rvalid : a_rvalid), 32'd1);
    chk(tag, 32'(is_b ? b_rdata : a_rdata), 32'(exp));
  endtask

  logic [3:0] rr_seq;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'($urandom);
    rst = 1'b1; preload = 1'b1; clr_start = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    @(posedge clk); #1;
    preload = 1'b0;
    model_reset();
    tick();                       // requests high during reset: no grants
    rst = 1'b0;
    a_req = 1'b0; b_req = 1'b0;

    // Round-robin from reset: A wins the first tie
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0; a_addr = 8'd3; b_addr = 8'd4;
    for (int i = 0; i < 4; i++) begin tick(); rr_seq[3-i] = a_gnt_seen(); end
    chk("rr_seq", 32'(rr_seq), 32'b1010);
    a_req = 1'b0;
    repeat (2) begin tick(); chk("b_only", 32'(gb), 32'd1); end
    idle(3);

    // Basic write then read back-to-back
    do_req(1'b0, 1'b1, 8'd5, 9'h1A5);
    chk("basic_we", 32'(mem_we), 32'd1);
    read_check(1'b0, 8'd5, 9'h1A5, "basic_rd");
    idle(2);

    // Alias: address folds modulo DEPTH
    do_req(1'b1, 1'b1, 8'h85, 9'h033);
    chk("alias_addr", 32'(mem_addr), 32'h05);
    chk("alias_wdata", 32'(mem_wdata), 32'h033);
    read_check(1'b0, 8'h05, 9'h033, "alias_rd");
    idle(2);

    // Clear sweep with a simultaneous A request held throughout
    do_req(1'b0, 1'b1, 8'd127, 9'h0FF);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'd127; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 200 && !ga; i++) tick();
    chk("clr_then_gnt", 32'(ga), 32'd1);
    a_req = 1'b0;
    tick();
    chk("clr_rd127", 32'(a_rdata), 32'h000);
    idle(2);

    // Read in flight across clear entry
    do_req(1'b0, 1'b1, 8'd20, 9'h0AB);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'd20;
    tick();
    a_req = 1'b0; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("inflight_busy", 32'(clr_busy), 32'd1);
    chk("inflight_rvalid", 32'(a_rvalid), 32'd1);
    chk("inflight_rdata", 32'(a_rdata), 32'h0AB);
    idle(135);

    // Reset while the sweep is presenting address 40
    do_req(1'b1, 1'b1, 8'd50, 9'h155);
    do_req(1'b1, 1'b1, 8'd10, 9'h0CC);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 200 && m_addr != 8'd40; i++) tick();
    chk("mid_addr40", 32'(mem_addr), 32'd40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy", 32'(clr_busy), 32'd0);
    chk("mid_we", 32'(mem_we), 32'd0);
    chk("mid_addr", 32'(mem_addr), 32'd0);
    idle(3);
    read_check(1'b0, 8'd50, 9'h155, "mid_rd50");
    read_check(1'b1, 8'd10, 9'h000, "mid_rd10");
    idle(2);

    // Randomized traffic with occasional clears and resets
    for (int c = 0; c < 1500; c++) begin
      if (!a_req) begin
        a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
        a_addr = ADDR_W'($urandom); a_wdata = DATA_W'($urandom);
      end
      if (!b_req) begin
        b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
        b_addr = ADDR_W'($urandom); b_wdata = DATA_W'($urandom);
      end
      clr_start = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
      if (ga) a_req = 1'b0;
      if (gb) b_req = 1'b0;
    end
    rst = 1'b0;
    idle(140);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic a_gnt_seen();
    return ga;
  endfunction

endmodule
